// File: rtl/hs4_mux_rx.sv
// Receive-domain terminator for CH 4-phase bundled-data channels: per-channel req
// synchroniser, capture FSM and FIFO, merged onto one valid/ready port by round-robin.
module hs4_mux_rx #(
  parameter int CH          = 4,
  parameter int W           = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CHW         = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [CH-1:0]   vi,
  input  logic [CH*W-1:0] indata,
  output logic [CH-1:0]   ack,
  output logic            vo,
  input  logic            rdy,
  output logic [W-1:0]    rdata,
  output logic [CHW-1:0]  rch,
  output logic [CH-1:0]   full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [SYNC_STAGES-1:0] sync_q [CH];
  logic [CH-1:0]          s_vi;
  state_t                 state [CH];
  state_t                 state_next [CH];
  logic [W-1:0]           mem [CH][DEPTH];
  logic [AW-1:0]          wptr [CH];
  logic [AW-1:0]          rptr [CH];
  logic [AW:0]            count [CH];
  logic [AW:0]            count_next [CH];
  logic [CH-1:0]          wr;
  logic [CH-1:0]          pop;
  logic [CH-1:0]          nonempty;
  logic [CHW-1:0]         rr_ptr;
  logic [CHW-1:0]         grant;
  logic                   grant_vld;
  logic                   load;
  int                     arb_idx;

  // Stage: request synchronisers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CH; c++) sync_q[c] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], vi[c]};
    end
  end

  // Capture FSM: full test uses the current count, so a same-cycle pop cannot admit a write.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      s_vi[c]       = sync_q[c][SYNC_STAGES-1];
      state_next[c] = state[c];
      wr[c]         = 1'b0;
      ack[c]        = (state[c] == HOLD);
      nonempty[c]   = (count[c] != '0);
      case (state[c])
        IDLE: if (s_vi[c] && (count[c] != FULL_CNT)) begin
          wr[c]         = 1'b1;
          state_next[c] = HOLD;
        end
        HOLD: if (!s_vi[c]) state_next[c] = IDLE;
        default: state_next[c] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      case ({wr[c], pop[c]})
        2'b10:   count_next[c] = count[c] + 1'b1;
        2'b01:   count_next[c] = count[c] - 1'b1;
        default: count_next[c] = count[c];
      endcase
    end
  end

  // Stage: FIFO control and channel state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CH; c++) begin
        state[c] <= IDLE;
        wptr[c]  <= '0;
        rptr[c]  <= '0;
        count[c] <= '0;
      end
      full <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        state[c] <= state_next[c];
        count[c] <= count_next[c];
        full[c]  <= (count[c] == FULL_CNT);
        if (wr[c])  wptr[c] <= wptr[c] + 1'b1;
        if (pop[c]) rptr[c] <= rptr[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (wr[c]) mem[c][wptr[c]] <= indata[c*W +: W];
    end
  end

  // Round-robin search starting at rr_ptr
  always_comb begin
    load      = !vo || rdy;
    grant     = '0;
    grant_vld = 1'b0;
    arb_idx   = 0;
    for (int i = 0; i < CH; i++) begin
      arb_idx = (int'(rr_ptr) + i) % CH;
      if (!grant_vld && nonempty[arb_idx]) begin
        grant     = CHW'(arb_idx);
        grant_vld = 1'b1;
      end
    end
    for (int c = 0; c < CH; c++) pop[c] = load && grant_vld && (grant == CHW'(c));
  end

  // Stage: output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vo     <= 1'b0;
      rdata  <= '0;
      rch    <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      if (grant_vld) begin
        vo     <= 1'b1;
        rdata  <= mem[grant][rptr[grant]];
        rch    <= grant;
        rr_ptr <= (grant == CHW'(CH-1)) ? '0 : grant + 1'b1;
      end else begin
        vo <= 1'b0;
      end
    end
  end

endmodule
